// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM scanout path.
//   VRAM_AW      : VRAM word-address width
//   WORD_BITS    : VRAM data width
//   SCREEN_WORDS : words per frame (512x256 at 1 bpp)
//   PIX_PER_WORD : pixels serialised from each word
//   ST_*         : fetch FSM state encodings
//   fetch_fsm_t  : complete fetch FSM state, kept as one struct so it can be
//                  probed as a unit
package vram_pkg;

    localparam int VRAM_AW      = 14;
    localparam int WORD_BITS    = 16;
    localparam int SCREEN_WORDS = 8192;
    localparam int PIX_PER_WORD = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    typedef struct packed {
        logic [1:0] state;
        logic [7:0] wait_cnt;
        logic       discard;
    } fetch_fsm_t;

endpackage

// File: rtl/scanout_fifo.sv
// Small synchronous FIFO used as the scanout prefetch buffer.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_flush        : empties the FIFO this cycle (wins over push/pop)
//   i_push, i_wdata: write one word (ignored when full)
//   i_pop          : read one word (ignored when empty)
//   o_rdata        : word at the head of the FIFO
//   o_count        : number of stored words
//   o_empty        : no words stored
// DEPTH must be a power of two so the pointers wrap naturally.
module scanout_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/vram_scanout.sv
// Display-side VRAM reader: fetches screen words sequentially, buffers them
// in a small FIFO to hide the VRAM read latency, and serialises each word
// LSB-first into 1-bit pixels on demand.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   frame_start : restart scanout at word 0 (pulse in vertical blanking)
//   pix_en      : consume one pixel this cycle
//   pixel       : current pixel (0 while no word is loaded)
//   underrun    : sticky, pix_en seen with no pixel available
//   rden, raddr : one-cycle VRAM read pulse and its held address
//   rdata       : VRAM read data, valid RD_LAT edges after rden is sampled
module vram_scanout #(
    parameter int RD_LAT       = 3,
    parameter int DEPTH        = 2,
    parameter int SCREEN_WORDS = vram_pkg::SCREEN_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          pix_en,
    output logic                          pixel,
    output logic                          underrun,
    output logic                          rden,
    output logic [vram_pkg::VRAM_AW-1:0]  raddr,
    input  logic [vram_pkg::WORD_BITS-1:0] rdata
);
    import vram_pkg::*;

    localparam int CNT_W = VRAM_AW - 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    fetch_fsm_t           r_fetch;
    logic                 r_rden;
    logic [VRAM_AW-1:0]   r_raddr;
    logic [CNT_W-1:0]     r_word_cnt;
    logic [WORD_BITS-1:0] r_shift_word;
    logic [3:0]           r_bit_idx;
    logic                 r_shift_valid;
    logic                 r_underrun;

    logic [WORD_BITS-1:0] w_fifo_rdata;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_last_bit;
    logic                 w_load;
    logic [CNT_W-1:0]     w_cnt_next;

    // Only IDLE can issue, and no read is outstanding in IDLE, so the FIFO
    // count alone measures committed words. No issue on a frame_start cycle:
    // the counter is being cleared and the read would target a stale word.
    assign w_issue    = (r_fetch.state == ST_IDLE) && (w_fifo_count < CW'(DEPTH)) && !frame_start;
    assign w_push     = (r_fetch.state == ST_CAPTURE) && !r_fetch.discard && !frame_start;
    assign w_cnt_next = (r_word_cnt == CNT_W'(SCREEN_WORDS - 1)) ? '0 : r_word_cnt + 1'b1;

    // The shifter reloads when empty, or on its last pixel for a zero-bubble
    // hand-over to the next word.
    assign w_last_bit = (r_bit_idx == 4'(PIX_PER_WORD - 1));
    assign w_load     = (!r_shift_valid || (pix_en && w_last_bit)) && !w_fifo_empty && !frame_start;

    assign rden     = r_rden;
    assign raddr    = r_raddr;
    assign underrun = r_underrun;
    assign pixel    = r_shift_valid & r_shift_word[r_bit_idx];

    scanout_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (frame_start),
        .i_push  (w_push),
        .i_wdata (rdata),
        .i_pop   (w_load),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Fetch FSM. rden is registered, so the first WAIT edge is the edge at
    // which the VRAM samples rden; CAPTURE then lands exactly RD_LAT edges
    // after that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch    <= '{state: ST_IDLE, wait_cnt: 8'd0, discard: 1'b0};
            r_rden     <= 1'b0;
            r_raddr    <= '0;
            r_word_cnt <= '0;
        end else begin
            r_rden <= 1'b0;
            case (r_fetch.state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_rden           <= 1'b1;
                        r_raddr          <= {1'b0, r_word_cnt};
                        r_fetch.wait_cnt <= 8'd0;
                        r_fetch.state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_fetch.wait_cnt == 8'(RD_LAT - 1)) r_fetch.state <= ST_CAPTURE;
                    else r_fetch.wait_cnt <= r_fetch.wait_cnt + 8'd1;
                end
                ST_CAPTURE: begin
                    // A discarded read was issued before a restart; the
                    // counter has already been cleared, so leave it alone.
                    if (!r_fetch.discard) r_word_cnt <= w_cnt_next;
                    r_fetch.discard <= 1'b0;
                    r_fetch.state   <= ST_IDLE;
                end
                default: r_fetch.state <= ST_IDLE;
            endcase
            if (frame_start) begin
                r_word_cnt <= '0;
                if (r_fetch.state == ST_WAIT) r_fetch.discard <= 1'b1;
            end
        end
    end

    // Pixel shifter and sticky underrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_word  <= '0;
            r_bit_idx     <= '0;
            r_shift_valid <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (pix_en && !r_shift_valid) r_underrun <= 1'b1;
            if (frame_start) begin
                r_shift_valid <= 1'b0;
                r_bit_idx     <= '0;
            end else if (w_load) begin
                r_shift_word  <= w_fifo_rdata;
                r_bit_idx     <= '0;
                r_shift_valid <= 1'b1;
            end else if (pix_en && r_shift_valid) begin
                if (w_last_bit) r_shift_valid <= 1'b0;
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: VRAM latency model, pixel stream
// scoreboard, fetch-address/spacing monitor and directed plus random phases.
module tb_vram_scanout;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 2;
    localparam int SW     = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_en;
    logic        pixel;
    logic        underrun;
    logic        rden;
    logic [13:0] raddr;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    vram_scanout #(
        .RD_LAT       (RD_LAT),
        .DEPTH        (DEPTH),
        .SCREEN_WORDS (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .pixel       (pixel),
        .underrun    (underrun),
        .rden        (rden),
        .raddr       (raddr),
        .rdata       (rdata)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] vram_word(input logic [13:0] a);
        return 16'hA5A5 ^ {2'b00, a};
    endfunction

    // VRAM model: data for a sampled read is valid RD_LAT edges later.
    logic [RD_LAT-1:0] rd_vld = '0;
    logic [13:0]       rd_addr [RD_LAT];
    always @(posedge clk) begin
        rd_vld     <= {rd_vld[RD_LAT-2:0], rden};
        rd_addr[0] <= raddr;
        for (int i = RD_LAT - 1; i > 0; i--) rd_addr[i] <= rd_addr[i-1];
    end
    assign rdata = rd_vld[RD_LAT-1] ? vram_word(rd_addr[RD_LAT-1]) : 16'hDEAD;

    // Pixel scoreboard: after a restart the stream is words 0,1,2,... LSB first.
    logic [0:0] exp_q[$];
    int         exp_word;
    bit         model_on;

    task automatic model_restart();
        exp_q.delete();
        exp_word = 0;
    endtask

    task automatic pop_expected(output logic b);
        logic [15:0] w;
        if (exp_q.size() == 0) begin
            w = vram_word(14'(exp_word));
            for (int k = 0; k < 16; k++) exp_q.push_back(w[k]);
            exp_word = (exp_word + 1) % SW;
        end
        b = exp_q.pop_front();
    endtask

    // Fetch monitor, sampled 1 time unit after each rising edge.
    int          cyc = 0;
    int          last_pulse = 0;
    bit          have_last = 0;
    logic        prev_rden = 1'b0;
    int          exp_addr = 0;
    int          prev_addr = -1;
    bit          saw_wrap = 0;
    logic [13:0] mon_log[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            exp_addr  = 0;
            have_last = 0;
            prev_rden = 1'b0;
        end else begin
            if (frame_start) exp_addr = 0;
            if (rden) begin
                check_eq("rden_width", prev_rden, 0);
                if (have_last) check_eq("rden_gap_ok", 32'((cyc - last_pulse) >= RD_LAT + 1), 1);
                check_eq("raddr_seq", raddr, exp_addr);
                if (raddr == 0 && prev_addr == SW - 1) saw_wrap = 1;
                prev_addr = raddr;
                mon_log.push_back(raddr);
                exp_addr   = (exp_addr + 1) % SW;
                last_pulse = cyc;
                have_last  = 1;
            end
            prev_rden = rden;
        end
    end

    // Driver: one call per clock; drives inputs at the falling edge and checks
    // the pixel being consumed against the scoreboard.
    task automatic step(input logic fs, input logic pe);
        logic e;
        @(negedge clk);
        if (pe && model_on) begin
            pop_expected(e);
            check_eq("pixel", pixel, e);
        end
        frame_start = fs;
        pix_en      = pe;
        if (fs) begin
            model_restart();
            mon_log.delete();
        end
    endtask

    bit found;

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        pix_en = 1'b0;
        model_on = 1;
        model_restart();
        repeat (3) @(negedge clk);
        check_eq("rst_rden", rden, 0);
        check_eq("rst_raddr", raddr, 0);
        check_eq("rst_pixel", pixel, 0);
        check_eq("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (30) step(1'b0, 1'b0);

        // Fetch spacing with no consumption: FIFO plus shifter fill, then stop.
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        check_eq("spacing_pulses", mon_log.size(), DEPTH + 1);
        for (int i = 0; i < mon_log.size() && i < 3; i++) check_eq("spacing_raddr", mon_log[i], i);

        // Basic scanout, pix_en from cycle 10.
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        repeat (48) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_eq("basic_fetched", 32'(mon_log.size() > 0), 1);
        check_eq("basic_first_raddr", mon_log[0], 0);
        check_eq("basic_underrun", underrun, 0);

        // Random consumption patterns, each after a restart.
        for (int r = 0; r < 4; r++) begin
            int n;
            step(1'b1, 1'b0);
            repeat (12) step(1'b0, 1'b0);
            n = $urandom_range(150, 400);
            for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 3) != 0));
            step(1'b0, 1'b0);
            check_eq("rand_underrun", underrun, 0);
        end

        // Full frame: addresses wrap from SW-1 back to 0.
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        saw_wrap = 0;
        repeat (SW * 16 + 48) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_eq("wrap_seen", saw_wrap, 1);
        check_eq("wrap_underrun", underrun, 0);

        // Underrun: pix_en right after frame_start.
        model_on = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check_eq("urun_pixel", pixel, 0);
        step(1'b0, 1'b0);
        check_eq("urun_set", underrun, 1);
        repeat (20) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_eq("urun_sticky", underrun, 1);
        model_on = 1;

        // Restart two cycles after the read of word 37 is issued.
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1'b0, 1'b1);
            if (rden && raddr == 14'd37) found = 1;
        end
        check_eq("mid_found", found, 1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        repeat (48) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_eq("mid_fetched", 32'(mon_log.size() > 0), 1);
        check_eq("mid_next_raddr", mon_log[0], 0);

        // Async reset while a read is in flight.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 1'b1);
            if (rden && raddr != 14'd0) found = 1;
        end
        check_eq("arst_found", found, 1);
        #2;
        pix_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_eq("arst_rden", rden, 0);
        check_eq("arst_raddr", raddr, 0);
        check_eq("arst_pixel", pixel, 0);
        check_eq("arst_underrun", underrun, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_eq("arst_fetched", 32'(mon_log.size() > 0), 1);
        check_eq("arst_first_raddr", mon_log[0], 0);
        repeat (32) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_eq("arst_underrun_after", underrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
